// File: rtl/vp_recovery_if.sv
// Signal bundle between the value-prediction responder and its environment.
// The slave modport is the responder; the master modport is everything around it.
interface vp_recovery_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  pred_start;
  logic [DATA_WIDTH-1:0] pred_value;
  logic [REG_ADDR_W-1:0] pred_dst;
  logic                  abort;
  logic                  busy;
  logic                  dc_valid;
  logic [DATA_WIDTH-1:0] dc_data;
  logic [REG_ADDR_W-1:0] snap_rd_addr;
  logic [DATA_WIDTH-1:0] snap_rd_data;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  recover_snapshot;
  logic                  recovery_done;
  logic                  pred_correct;
  logic [15:0]           stat_correct;
  logic [15:0]           stat_mispredict;

  modport master (
    output pred_start, pred_value, pred_dst, abort, dc_valid, dc_data, snap_rd_data,
    input  busy, snap_rd_addr, rf_we, rf_waddr, rf_wdata,
    input  recover_snapshot, recovery_done, pred_correct, stat_correct, stat_mispredict
  );

  modport slave (
    input  pred_start, pred_value, pred_dst, abort, dc_valid, dc_data, snap_rd_data,
    output busy, snap_rd_addr, rf_we, rf_waddr, rf_wdata,
    output recover_snapshot, recovery_done, pred_correct, stat_correct, stat_mispredict
  );
endinterface

// File: rtl/vp_recovery_unit.sv
// Load value-prediction responder: verifies a predicted load value and, on a mismatch,
// restores the register file from the snapshot store. Optional counters: VP_STATS_EN.
module vp_recovery_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5   // 2**REG_ADDR_W must be >= NUM_REGS
) (
  input logic           clk,
  input logic           rst,
  vp_recovery_if.slave  bus
);

  // One extra bit so the counter can hold NUM_REGS itself (the final write-back cycle).
  localparam int CNT_W = REG_ADDR_W + 1;
  localparam logic [CNT_W-1:0]      LAST_K   = CNT_W'(NUM_REGS);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [REG_ADDR_W-1:0] ADDR_ONE = REG_ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RESTORE,
    S_FIXUP,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pred_value_q, pred_value_d;
  logic [REG_ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_WIDTH-1:0] dc_data_q, dc_data_d;
  logic                  pred_correct_q, pred_correct_d;

  logic                  busy;
  logic                  recover;
  logic                  done;
  logic                  mispredict_evt;
  logic [REG_ADDR_W-1:0] snap_addr;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [REG_ADDR_W-1:0] restore_waddr;

  // Write index trails the read index by one because the snapshot has one-cycle latency.
  // At k = NUM_REGS the low bits wrap to 0, so subtracting one yields NUM_REGS-1 as needed.
  assign restore_waddr = cnt_q[REG_ADDR_W-1:0] - ADDR_ONE;

  // NOTE: every signal written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pred_value_d   = pred_value_q;
    dst_d          = dst_q;
    dc_data_d      = dc_data_q;
    pred_correct_d = 1'b0;
    busy           = 1'b0;
    recover        = 1'b0;
    done           = 1'b0;
    mispredict_evt = 1'b0;
    snap_addr      = '0;
    rf_we          = 1'b0;
    rf_waddr       = '0;
    rf_wdata       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.pred_start) begin
          pred_value_d = bus.pred_value;
          dst_d        = bus.pred_dst;
          state_d      = S_WAIT;
        end
      end

      S_WAIT: begin
        busy = 1'b1;
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.dc_valid) begin
          if (bus.dc_data == pred_value_q) begin
            pred_correct_d = 1'b1;
            state_d        = S_IDLE;
          end else begin
            dc_data_d      = bus.dc_data;
            cnt_d          = '0;
            mispredict_evt = 1'b1;
            state_d        = S_RESTORE;
          end
        end
      end

      S_RESTORE: begin
        busy    = 1'b1;
        recover = 1'b1;
        if (cnt_q < LAST_K) begin
          snap_addr = cnt_q[REG_ADDR_W-1:0];
        end
        if (cnt_q != '0) begin
          rf_waddr = restore_waddr;
          rf_wdata = bus.snap_rd_data;
          rf_we    = (restore_waddr != '0);
        end
        if (cnt_q == LAST_K) begin
          state_d = S_FIXUP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_FIXUP: begin
        busy     = 1'b1;
        recover  = 1'b1;
        rf_we    = (dst_q != '0);
        rf_waddr = dst_q;
        rf_wdata = dc_data_q;
        state_d  = S_DONE;
      end

      S_DONE: begin
        busy    = 1'b1;
        recover = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      pred_value_q   <= '0;
      dst_q          <= '0;
      dc_data_q      <= '0;
      pred_correct_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pred_value_q   <= pred_value_d;
      dst_q          <= dst_d;
      dc_data_q      <= dc_data_d;
      pred_correct_q <= pred_correct_d;
    end
  end

`ifdef VP_STATS_EN
  logic [15:0] stat_correct_q, stat_correct_d;
  logic [15:0] stat_mispredict_q, stat_mispredict_d;

  // Counters saturate rather than wrap so a long run never reports a misleading small value.
  always_comb begin
    stat_correct_d    = stat_correct_q;
    stat_mispredict_d = stat_mispredict_q;
    if (pred_correct_d && (stat_correct_q != 16'hFFFF)) begin
      stat_correct_d = stat_correct_q + 16'd1;
    end
    if (mispredict_evt && (stat_mispredict_q != 16'hFFFF)) begin
      stat_mispredict_d = stat_mispredict_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_correct_q    <= '0;
      stat_mispredict_q <= '0;
    end else begin
      stat_correct_q    <= stat_correct_d;
      stat_mispredict_q <= stat_mispredict_d;
    end
  end

  assign bus.stat_correct    = stat_correct_q;
  assign bus.stat_mispredict = stat_mispredict_q;
`else
  assign bus.stat_correct    = 16'h0000;
  assign bus.stat_mispredict = 16'h0000;
`endif

  assign bus.busy             = busy;
  assign bus.recover_snapshot = recover;
  assign bus.recovery_done    = done;
  assign bus.pred_correct     = pred_correct_q;
  assign bus.snap_rd_addr     = snap_addr;
  assign bus.rf_we            = rf_we;
  assign bus.rf_waddr         = rf_waddr;
  assign bus.rf_wdata         = rf_wdata;

endmodule

// File: tb/tb_vp_recovery_unit.sv
// Directed bench for vp_recovery_unit: a vector table of verify/recover transactions
// plus hand-written abort, back-to-back and mid-restore reset sequences.
module tb_vp_recovery_unit;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vp_recovery_if #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) bus ();

  vp_recovery_unit #(.DATA_WIDTH(DW), .NUM_REGS(NR), .REG_ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Snapshot store model: reg i holds i*16, one-cycle read latency.
  logic [DW-1:0] snap_mem [NR];
  always @(posedge clk) bus.snap_rd_data <= snap_mem[bus.snap_rd_addr];

  logic [DW-1:0] rf_model [NR];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_correct_cnt = 0;
  int exp_mis_cnt     = 0;

  typedef struct {
    logic [DW-1:0] pred_value;
    logic [AW-1:0] dst;
    logic [DW-1:0] dc_data;
    int            delay;
    bit            exp_match;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.pred_start = 1'b0;
    bus.pred_value = '0;
    bus.pred_dst   = '0;
    bus.abort      = 1'b0;
    bus.dc_valid   = 1'b0;
    bus.dc_data    = '0;
  endtask

  // Move from the sample point of one cycle to the drive point of the next.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
`ifdef VP_STATS_EN
    check({tag, "_stat_correct"}, 32'(bus.stat_correct), 32'(exp_correct_cnt));
    check({tag, "_stat_mispredict"}, 32'(bus.stat_mispredict), 32'(exp_mis_cnt));
`else
    check({tag, "_stat_correct"}, 32'(bus.stat_correct), 32'h0);
    check({tag, "_stat_mispredict"}, 32'(bus.stat_mispredict), 32'h0);
`endif
  endtask

  // Cycle 0 issues the prediction, cycle v.delay (= T) returns the D-cache data.
  task automatic run_txn(input int idx, input vec_t v);
    int   pc_cnt = 0, pc_cyc = -1, wr_cnt = 0, reg1_cyc = -1, dst_wr_cyc = -1;
    int   rec_cnt = 0, done_cnt = 0, done_cyc = -1, busy_fall = -1, bad_regs = 0;
    logic reg0_wr = 1'b0;
    int   t = v.delay;
    logic [DW-1:0] exp_val;
    string tag = $sformatf("v%0d", idx);

    for (int i = 0; i < NR; i++) rf_model[i] = 32'hDEAD_0000 | i;

    for (int c = 0; c <= t + 40; c++) begin
      bus.pred_start = (c == 0);
      bus.pred_value = v.pred_value;
      bus.pred_dst   = v.dst;
      bus.dc_valid   = (c == t);
      bus.dc_data    = v.dc_data;
      @(negedge clk);
      if (bus.pred_correct) begin pc_cnt++; pc_cyc = c; end
      if (bus.rf_we) begin
        wr_cnt++;
        if (bus.rf_waddr == '0) reg0_wr = 1'b1;
        if (bus.rf_waddr == 5'd1 && reg1_cyc < 0) reg1_cyc = c;
        if (bus.rf_waddr == v.dst) dst_wr_cyc = c;
        rf_model[bus.rf_waddr] = bus.rf_wdata;
      end
      if (bus.recover_snapshot) rec_cnt++;
      if (bus.recovery_done) begin done_cnt++; done_cyc = c; end
      if (c > t && !bus.busy && busy_fall < 0) busy_fall = c;
      next_cycle();
    end
    clear_inputs();

    if (v.exp_match) begin
      exp_correct_cnt++;
      check({tag, "_pred_correct_count"}, 32'(pc_cnt), 32'd1);
      check({tag, "_pred_correct_cycle"}, 32'(pc_cyc), 32'(t + 1));
      check({tag, "_rf_writes"}, 32'(wr_cnt), 32'd0);
      check({tag, "_recover_cycles"}, 32'(rec_cnt), 32'd0);
      check({tag, "_busy_fall"}, 32'(busy_fall), 32'(t + 1));
      check({tag, "_recovery_done_count"}, 32'(done_cnt), 32'd0);
    end else begin
      exp_mis_cnt++;
      for (int i = 1; i < NR; i++) begin
        exp_val = (v.dst != '0 && i == int'(v.dst)) ? v.dc_data : DW'(i * 16);
        if (rf_model[i] !== exp_val) bad_regs++;
      end
      check({tag, "_pred_correct_count"}, 32'(pc_cnt), 32'd0);
      check({tag, "_rf_writes"}, 32'(wr_cnt), 32'(31 + ((v.dst != '0) ? 1 : 0)));
      check({tag, "_reg0_written"}, 32'(reg0_wr), 32'd0);
      check({tag, "_bad_restored_regs"}, 32'(bad_regs), 32'd0);
      check({tag, "_reg1_write_cycle"}, 32'(reg1_cyc), 32'(t + 3));
      if (v.dst != '0) check({tag, "_fixup_cycle"}, 32'(dst_wr_cyc), 32'(t + 34));
      check({tag, "_recover_cycles"}, 32'(rec_cnt), 32'(NR + 3));
      check({tag, "_recovery_done_count"}, 32'(done_cnt), 32'd1);
      check({tag, "_recovery_done_cycle"}, 32'(done_cyc), 32'(t + 35));
      check({tag, "_busy_fall"}, 32'(busy_fall), 32'(t + 36));
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int bad;

    vecs[0] = '{pred_value: 32'h0000_1234, dst: 5'd5,  dc_data: 32'h0000_1234, delay: 3, exp_match: 1'b1};
    vecs[1] = '{pred_value: 32'h0000_000A, dst: 5'd7,  dc_data: 32'h0000_000B, delay: 3, exp_match: 1'b0};
    vecs[2] = '{pred_value: 32'h0000_0055, dst: 5'd0,  dc_data: 32'h0000_0056, delay: 2, exp_match: 1'b0};
    vecs[3] = '{pred_value: 32'hFFFF_FFFF, dst: 5'd31, dc_data: 32'hFFFF_FFFF, delay: 1, exp_match: 1'b1};
    vecs[4] = '{pred_value: 32'h0000_0000, dst: 5'd12, dc_data: 32'h0000_0000, delay: 5, exp_match: 1'b1};

    for (int i = 0; i < NR; i++) snap_mem[i] = DW'(i * 16);
    clear_inputs();

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_recover", 32'(bus.recover_snapshot), 32'd0);
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_pred_correct", 32'(bus.pred_correct), 32'd0);
    check("rst_recovery_done", 32'(bus.recovery_done), 32'd0);
    check("rst_snap_addr", 32'(bus.snap_rd_addr), 32'd0);
    check_stats("rst");
    next_cycle();

    for (int i = 0; i < 5; i++) begin
      run_txn(i, vecs[i]);
      next_cycle();
    end
    @(negedge clk);
    check_stats("table");
    next_cycle();

    // Abort and mismatching dc_valid together: abort wins, then dc_valid in IDLE is ignored.
    bad = 0;
    bus.pred_start = 1'b1; bus.pred_value = 32'd100; bus.pred_dst = 5'd3;
    next_cycle();
    clear_inputs();
    next_cycle();
    bus.abort = 1'b1; bus.dc_valid = 1'b1; bus.dc_data = 32'd101;
    @(negedge clk);
    check("abort_busy_in_wait", 32'(bus.busy), 32'd1);
    next_cycle();
    clear_inputs();
    for (int c = 0; c < 6; c++) begin
      bus.dc_valid = (c == 1);
      bus.dc_data  = 32'd101;
      @(negedge clk);
      if (c == 0) check("abort_busy_after", 32'(bus.busy), 32'd0);
      if (bus.rf_we || bus.recover_snapshot || bus.pred_correct || bus.recovery_done || bus.busy) bad++;
      next_cycle();
    end
    clear_inputs();
    check("abort_spurious_activity", 32'(bad), 32'd0);

    // Back-to-back: a new prediction is accepted on the first IDLE cycle.
    bus.pred_start = 1'b1; bus.pred_value = 32'd7; bus.pred_dst = 5'd2;
    next_cycle();
    clear_inputs();
    bus.dc_valid = 1'b1; bus.dc_data = 32'd7;
    next_cycle();
    clear_inputs();
    bus.pred_start = 1'b1; bus.pred_value = 32'd9; bus.pred_dst = 5'd4;
    @(negedge clk);
    check("b2b_first_correct", 32'(bus.pred_correct), 32'd1);
    check("b2b_idle_busy", 32'(bus.busy), 32'd0);
    next_cycle();
    clear_inputs();
    bus.dc_valid = 1'b1; bus.dc_data = 32'd9;
    @(negedge clk);
    check("b2b_second_accepted", 32'(bus.busy), 32'd1);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("b2b_second_correct", 32'(bus.pred_correct), 32'd1);
    exp_correct_cnt += 2;
    next_cycle();
    @(negedge clk);
    check_stats("b2b");
    next_cycle();

    // Reset at RESTORE k=10: compare at cycle 1, so k=10 falls on cycle 12.
    for (int c = 0; c <= 12; c++) begin
      bus.pred_start = (c == 0); bus.pred_value = 32'hA; bus.pred_dst = 5'd7;
      bus.dc_valid   = (c == 1); bus.dc_data   = 32'hB;
      rst = (c == 12);
      @(negedge clk);
      if (c == 12) begin
        check("rstmid_restore_active", 32'(bus.rf_we), 32'd1);
        check("rstmid_restore_waddr", 32'(bus.rf_waddr), 32'd9);
      end
      next_cycle();
    end
    rst = 1'b0;
    clear_inputs();
    exp_correct_cnt = 0;
    exp_mis_cnt     = 0;
    bus.pred_start = 1'b1; bus.pred_value = 32'h5; bus.pred_dst = 5'd1;
    @(negedge clk);
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    check("rstmid_recover", 32'(bus.recover_snapshot), 32'd0);
    check("rstmid_rf_we", 32'(bus.rf_we), 32'd0);
    check("rstmid_snap_addr", 32'(bus.snap_rd_addr), 32'd0);
    check("rstmid_recovery_done", 32'(bus.recovery_done), 32'd0);
    check_stats("rstmid");
    next_cycle();
    clear_inputs();
    bus.dc_valid = 1'b1; bus.dc_data = 32'h5;
    @(negedge clk);
    check("rstmid_new_pred_accepted", 32'(bus.busy), 32'd1);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("rstmid_new_pred_correct", 32'(bus.pred_correct), 32'd1);
    exp_correct_cnt++;
    next_cycle();
    @(negedge clk);
    check_stats("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
